// File: rtl/phase_commit_scheduler_pkg.sv
// Shared definitions for the phase commit path: the commit FSM state type and
// the period / phase-width derivation used by the host receiver, this
// scheduler and the per-channel generators.
package phase_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACK   = 2'd2
  } phase_commit_state_t;

  // Output period in system clock ticks.
  function automatic int unsigned period_of(input int unsigned clk_freq,
                                            input int unsigned out_freq);
    return clk_freq / out_freq;
  endfunction

  // Width of a phase word, which must hold any tick offset within a period.
  function automatic int unsigned phase_w_of(input int unsigned clk_freq,
                                             input int unsigned out_freq);
    return $clog2(clk_freq / out_freq);
  endfunction

endpackage

// File: rtl/phase_commit_scheduler_period_counter.sv
// Master output-period counter.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   count         current tick within the period, 0..PERIOD-1
//   wrap_next     high on the last tick of the period (count == PERIOD-1)
//   period_start  high on tick 0 of each period, held low during reset
module period_counter
  import phase_sched_pkg::*;
#(
  parameter  int unsigned PERIOD = 2500,
  localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          wrap_next,
  output logic          period_start
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_q == CW'(PERIOD - 1)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count        = count_q;
  assign wrap_next    = (count_q == CW'(PERIOD - 1));
  assign period_start = (count_q == '0) && !rst;

endmodule

// File: rtl/phase_commit_scheduler.sv
// Phase commit scheduler: gathers per-channel phase writes into a shadow bank
// and, on a host commit request, copies the whole bank to the active bank at
// the next output-period boundary so all channels change phase coherently.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_valid/ready    phase write handshake (ready only in IDLE)
//   wr_addr, wr_phase target channel and phase value in clock ticks
//   commit_req        single-cycle request to commit the shadow bank
//   commit_ack        pulse on the cycle the active bank updates
//   period_start      pulse on counter == 0, exported to the generators
//   active_phases     phases currently driving the generators
//   pending           shadow holds writes not yet committed
//   addr_error        sticky out-of-range write flag, cleared by clear_error
//   commit_count      number of commits, wraps at 8 bits
module phase_commit_scheduler
  import phase_sched_pkg::*;
#(
  parameter  int unsigned CLK_FREQ     = 100000000,
  parameter  int unsigned OUT_FREQ     = 40000,
  parameter  int unsigned NUM_CHANNELS = 256,
  localparam int unsigned PERIOD       = period_of(CLK_FREQ, OUT_FREQ),
  localparam int unsigned PHASE_W      = phase_w_of(CLK_FREQ, OUT_FREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [7:0]         wr_addr,
  input  logic [PHASE_W-1:0] wr_phase,
  input  logic               commit_req,
  output logic               commit_ack,
  output logic               period_start,
  output logic [PHASE_W-1:0] active_phases [NUM_CHANNELS],
  output logic               pending,
  output logic               addr_error,
  input  logic               clear_error,
  output logic [7:0]         commit_count
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  phase_commit_state_t state_q;
  logic [PHASE_W-1:0]  shadow_q [NUM_CHANNELS];
  logic [PHASE_W-1:0]  active_q [NUM_CHANNELS];
  logic                commit_ack_q;
  logic                pending_q;
  logic                addr_error_q;
  logic [7:0]          commit_count_q;

  logic                wrap_next;
  logic [CW-1:0]       count_unused;  // tick value not needed by the FSM
  logic                wr_fire;
  logic                addr_ok;

  period_counter #(
    .PERIOD(PERIOD)
  ) u_period_counter (
    .clk         (clk),
    .rst         (rst),
    .count       (count_unused),
    .wrap_next   (wrap_next),
    .period_start(period_start)
  );

  assign wr_ready = (state_q == IDLE) && !rst;
  assign wr_fire  = wr_valid && wr_ready;
  assign addr_ok  = ({24'd0, wr_addr} < NUM_CHANNELS);

  // The copy is launched on the last tick of the period so that the new bank,
  // commit_ack and the ACK state all land together on counter == 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      commit_ack_q   <= 1'b0;
      pending_q      <= 1'b0;
      addr_error_q   <= 1'b0;
      commit_count_q <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      commit_ack_q <= 1'b0;

      if (clear_error) begin
        addr_error_q <= 1'b0;
      end else if (wr_fire && !addr_ok) begin
        addr_error_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (wr_fire && addr_ok) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
              if (wr_addr == 8'(i)) begin
                shadow_q[i] <= wr_phase;
              end
            end
            pending_q <= 1'b1;
          end
          if (commit_req) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (wrap_next) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
              active_q[i] <= shadow_q[i];
            end
            commit_ack_q   <= 1'b1;
            pending_q      <= 1'b0;
            commit_count_q <= commit_count_q + 8'd1;
            state_q        <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign active_phases = active_q;
  assign commit_ack    = commit_ack_q;
  assign pending       = pending_q;
  assign addr_error    = addr_error_q;
  assign commit_count  = commit_count_q;

endmodule

// File: doc/phase_commit_scheduler.md
Name: phase_commit_scheduler

Overview:
- Sits between the host command receiver and the per-channel phase generators.
- Collects per-channel phase writes into a shadow bank. On a host commit request, copies the whole shadow bank to the active bank at the next output-period boundary, so all transducer channels change phase coherently.
- Owns the master output-period counter and exports its boundary pulse to the channel generators.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- OUT_FREQ, 40000, transducer drive frequency in Hz. PERIOD = CLK_FREQ/OUT_FREQ (derived localparam).
- NUM_CHANNELS, 256, number of output channels.
- PHASE_W, $clog2(CLK_FREQ/OUT_FREQ), phase word width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  phase write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  8  target channel index.
- wr_phase  in  PHASE_W  phase value, in clock ticks.
- commit_req  in  1  single-cycle request to commit the shadow bank.
- commit_ack  out  1  pulse on the cycle the active bank updates.
- period_start  out  1  pulse on the cycle the period counter == 0.
- active_phases  out  PHASE_W x NUM_CHANNELS  unpacked array, phases driving the generators.
- pending  out  1  shadow holds writes not yet committed.
- addr_error  out  1  sticky: out-of-range write seen.
- clear_error  in  1  clears addr_error.
- commit_count  out  8  number of commits, wraps 255->0.

Behaviour:
- Reset values: counter 0; shadow and active banks all 0; state IDLE; commit_ack 0; pending 0; addr_error 0; commit_count 0. While rst is high, wr_ready=0 and period_start=0.
- Period counter: counts 0..PERIOD-1, then wraps. Counter = 0 on the first cycle after rst deasserts. period_start is high exactly when counter == 0 and not in reset.
- FSM states:
  - IDLE: wr_ready=1.
    - Accepted write with wr_addr < NUM_CHANNELS: shadow[wr_addr] <= wr_phase; pending <= 1.
    - wr_addr >= NUM_CHANNELS: write dropped; addr_error <= 1.
    - commit_req: go to ARMED. A write and commit_req in the same cycle are both honoured; the write is included in the commit.
  - ARMED: wr_ready=0 (writes stall, not dropped). commit_req is ignored.
    - When counter == PERIOD-1: active <= shadow (all channels, one cycle), then go to ACK.
  - ACK: lasts one cycle.
    - commit_ack=1, pending <= 0, commit_count += 1.
    - Coincides with counter == 0 / period_start.
    - Returns to IDLE. wr_ready=0 during ACK.
- Commit latency: commit_req at counter value c (in IDLE) gives active change and commit_ack at the next cycle where counter == 0 after ARMED has been entered. Worst case is PERIOD+1 cycles (request at c = PERIOD-1).
- Commit with pending=0 is legal: bank is re-copied unchanged, and commit_ack and commit_count still advance.
- active_phases changes only in the ACK-aligned cycle, never mid-period.
- addr_error:
  - clear_error has priority over a simultaneous set.
  - A set in a later cycle re-asserts it.
- rst mid-operation (ARMED or ACK): aborts the commit; the active bank returns to 0 next cycle; no commit_ack is emitted.

Decomposition:
- Package phase_sched_pkg holds:
  - enum phase_commit_state_t {IDLE, ARMED, ACK};
  - the PERIOD/PHASE_W derivation function, shared with the receiver and the generators.
- One sub-module, period_counter (params PERIOD; outputs count, wrap_next = count==PERIOD-1, period_start).

Test Plan:
Bench params: CLK_FREQ=16, OUT_FREQ=1 (PERIOD=16, PHASE_W=4), NUM_CHANNELS=4.
1. Release rst -> period_start high on cycles 0, 16, 32; all active_phases=0; wr_ready=1; commit_count=0.
2. Write ch0=5, ch3=9 at counter 2,3, then commit_req at counter 4:
   - pending=1 until the commit;
   - active_phases stays {0,0,0,0} through counter 15;
   - at counter 0, active={5,0,0,9}, commit_ack=1, commit_count=1, pending=0.
3. commit_req at counter 15 -> ARMED for 16 cycles; commit_ack at the second following counter==0 (latency 17 cycles). wr_valid held during ARMED stalls, then the write lands in shadow only after ACK.
4. Write wr_addr=4, phase=7 -> addr_error=1 and no bank changes. Then clear_error and a bad write in the same cycle -> addr_error=0. Next bad write -> 1.
5. commit_req and write ch1=3 in the same IDLE cycle -> ch1=3 appears in active at the commit. A second commit_req during ARMED -> exactly one commit_ack.
6. Assert rst for one cycle while ARMED at counter 10 -> no commit_ack; active all 0; counter restarts at 0; shadow cleared (a subsequent commit yields all 0).
